// File: rtl/dram_wrbuf.sv
// dram_wrbuf: write buffer between a streaming producer and a DRAM controller.
// Elements go into a 2^DEPTH_LOG-entry FIFO. Full bursts of BURST elements are
// written to consecutive addresses. A FLUSH also forces out a partial burst.
//
// Ports:
//   CLK, RST_X            clock, asynchronous active-low reset
//   IN_DATA, IN_ENQ       producer side; IN_FULL reports a full FIFO
//   FLUSH                 write out everything that is buffered; DONE pulses when finished
//   D_REQ, D_INITADR,     write request to the DRAM controller (start address and
//   D_ELEM                element count are held until the next request)
//   D_DIN, D_W            FIFO head (fall-through) and the controller's consume strobe
//   D_BUSY                controller busy; no request is issued while it is high
//   OVF                   sticky: an enqueue was dropped because the FIFO was full
//   WCOUNT                running total of consumed elements (wraps)
//
// state | meaning
// IDLE  | waiting for a full burst, or for a pending flush with data
// REQ   | D_REQ asserted for one cycle
// XFER  | controller consumes the burst via D_W
// DRAIN | burst done, waiting for the controller to go idle

`ifndef APPDATA_WIDTH
`define APPDATA_WIDTH 512
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif

module dram_wrbuf #(
    parameter int unsigned DW        = `APPDATA_WIDTH,
    parameter int unsigned DEPTH_LOG = 6,
    parameter int unsigned BURST     = 16,
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter logic [31:0] ADR_SPAN  = 32'h0800_0000
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_ENQ,
    output logic          IN_FULL,
    input  logic          FLUSH,
    output logic [1:0]    D_REQ,
    output logic [31:0]   D_INITADR,
    output logic [31:0]   D_ELEM,
    output logic [DW-1:0] D_DIN,
    input  logic          D_W,
    input  logic          D_BUSY,
    output logic          DONE,
    output logic          OVF,
    output logic [31:0]   WCOUNT
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned CW    = DEPTH_LOG + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_XFER  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         remain_q, remain_d;
    logic [31:0]           elem_q, adr_q, next_adr_q;
    logic                  flush_pend_q, done_q, ovf_q;
    logic [31:0]           wcount_q;

    logic                  full;
    logic                  enq_ok;
    logic                  pop;
    logic                  burst_ready;
    logic                  flush_clr;
    logic                  launch;
    logic [CW-1:0]         elem_sel;
    logic [32:0]           adr_sum;
    logic [31:0]           next_adr_d;

    assign full     = (count_q == DEPTH_C);
    // full is judged on the occupancy before any same-cycle pop
    assign enq_ok   = IN_ENQ & ~full;
    // D_W is only honoured while a burst is actually in flight
    assign pop      = D_W & (state_q == S_XFER);
    assign elem_sel = (count_q >= BURST_C) ? BURST_C : count_q;

    assign burst_ready = ~D_BUSY &
                         ((count_q >= BURST_C) | (flush_pend_q & (count_q != '0)));
    assign flush_clr   = (state_q == S_IDLE) & flush_pend_q & (count_q == '0);

    // 33-bit sum so that a span near 2^32 cannot lose the carry before the modulo
    assign adr_sum    = {1'b0, next_adr_q} + {elem_q[29:0], 3'b000};
    assign next_adr_d = 32'(adr_sum % {1'b0, ADR_SPAN});

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        launch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (burst_ready) begin
                    state_d  = S_REQ;
                    remain_d = elem_sel;
                    launch   = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_XFER;
            end
            S_XFER: begin
                if (pop) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!D_BUSY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= S_IDLE;
            remain_q     <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            elem_q       <= '0;
            adr_q        <= '0;
            next_adr_q   <= BASE_ADR;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wcount_q     <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            if (enq_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q   <= rptr_q + 1'b1;
                wcount_q <= wcount_q + 32'd1;
            end
            case ({enq_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (launch) begin
                elem_q <= 32'(elem_sel);
                adr_q  <= next_adr_q;
            end
            if (state_q == S_REQ) begin
                next_adr_q <= next_adr_d;
            end
            // a FLUSH arriving while one is already pending is absorbed by it
            if (flush_pend_q) begin
                flush_pend_q <= ~flush_clr;
            end else begin
                flush_pend_q <= FLUSH;
            end
            done_q <= flush_clr;
            if (IN_ENQ && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            mem_q[wptr_q] <= IN_DATA;
        end
    end

    assign IN_FULL   = full;
    assign D_REQ     = (state_q == S_REQ) ? `DRAM_REQ_WRITE : 2'b00;
    assign D_INITADR = adr_q;
    assign D_ELEM    = elem_q;
    assign D_DIN     = mem_q[rptr_q];
    assign DONE      = done_q;
    assign OVF       = ovf_q;
    assign WCOUNT    = wcount_q;

endmodule

// File: tb/tb_dram_wrbuf.sv
// Testbench for dram_wrbuf with BURST=4, DEPTH_LOG=3, BASE_ADR=0, ADR_SPAN=64.
// Directed table of per-cycle vectors, hand-written reset/flush/wrap sequences,
// then a randomized run against a queue-based reference model.
module tb_dram_wrbuf;
    localparam int DW = 32;
    localparam logic [1:0] WR = `DRAM_REQ_WRITE;

    logic          CLK = 1'b0;
    logic          RST_X;
    logic [DW-1:0] IN_DATA;
    logic          IN_ENQ;
    logic          IN_FULL;
    logic          FLUSH;
    logic [1:0]    D_REQ;
    logic [31:0]   D_INITADR;
    logic [31:0]   D_ELEM;
    logic [DW-1:0] D_DIN;
    logic          D_W;
    logic          D_BUSY;
    logic          DONE;
    logic          OVF;
    logic [31:0]   WCOUNT;

    always #5 CLK = ~CLK;

    dram_wrbuf #(
        .DW(DW), .DEPTH_LOG(3), .BURST(4), .BASE_ADR(32'd0), .ADR_SPAN(32'd64)
    ) dut (
        .CLK(CLK), .RST_X(RST_X), .IN_DATA(IN_DATA), .IN_ENQ(IN_ENQ), .IN_FULL(IN_FULL),
        .FLUSH(FLUSH), .D_REQ(D_REQ), .D_INITADR(D_INITADR), .D_ELEM(D_ELEM),
        .D_DIN(D_DIN), .D_W(D_W), .D_BUSY(D_BUSY), .DONE(DONE), .OVF(OVF), .WCOUNT(WCOUNT)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        enq;
        logic [31:0] data;
        logic        flush;
        logic        dw;
        logic        busy;
        logic        chk_din;
        logic [31:0] din;
        logic        full;
        logic [1:0]  req;
        logic [31:0] adr;
        logic [31:0] elem;
        logic [31:0] wc;
        logic        done;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(input logic enq, input logic [31:0] data, input logic flush,
                                input logic dw, input logic busy, input logic chk_din,
                                input logic [31:0] din, input logic full, input logic r,
                                input logic [31:0] adr, input logic [31:0] elem,
                                input logic [31:0] wc, input logic done, input logic ovf);
        vec_t v;
        v.enq = enq; v.data = data; v.flush = flush; v.dw = dw; v.busy = busy;
        v.chk_din = chk_din; v.din = din; v.full = full; v.req = r ? WR : 2'b00;
        v.adr = adr; v.elem = elem; v.wc = wc; v.done = done; v.ovf = ovf;
        return v;
    endfunction

    // reference model state
    logic [31:0] m_q[$];
    int unsigned m_wcount;
    logic        m_ovf;
    logic        m_flush;
    int unsigned exp_adr;
    int unsigned xfer_rem;
    int unsigned prev_size;
    logic        prev_busy;
    logic        done_seen;

    task automatic drive_idle();
        IN_ENQ = 1'b0; IN_DATA = '0; FLUSH = 1'b0; D_W = 1'b0; D_BUSY = 1'b0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wcount = 0; m_ovf = 1'b0; m_flush = 1'b0; exp_adr = 0;
        xfer_rem = 0; prev_size = 0; prev_busy = 1'b0; done_seen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, ".req"},    32'(D_REQ), 32'd0);
        check32({tag, ".adr"},    D_INITADR, 32'd0);
        check32({tag, ".elem"},   D_ELEM, 32'd0);
        check32({tag, ".done"},   32'(DONE), 32'd0);
        check32({tag, ".ovf"},    32'(OVF), 32'd0);
        check32({tag, ".wcount"}, WCOUNT, 32'd0);
        check32({tag, ".full"},   32'(IN_FULL), 32'd0);
    endtask

    // enqueue one full burst and play the controller for it
    task automatic burst(input logic [31:0] base, input logic [31:0] adr);
        bit found;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            IN_ENQ = 1'b1; IN_DATA = base + 32'(k); D_BUSY = 1'b0;
        end
        @(negedge CLK);
        IN_ENQ = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (D_REQ == WR) found = 1'b1;
            else @(negedge CLK);
        end
        if (!found) begin
            vectors++; miscompares++;
            $display("FAIL burst_timeout: got no request expected request at %h", adr);
            return;
        end
        check32("wrap.adr", D_INITADR, adr);
        check32("wrap.elem", D_ELEM, 32'd4);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            check32("wrap.din", D_DIN, base + 32'(k));
            D_W = 1'b1; D_BUSY = 1'b1;
            @(negedge CLK);
        end
        D_W = 1'b0; D_BUSY = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic rand_cycle(input bit allow_enq, input bit force_flush);
        bit req_now;
        bit was_full;
        int unsigned e;
        @(negedge CLK);
        check32("rnd.full", 32'(IN_FULL), 32'(m_q.size() == 8));
        check32("rnd.wcount", WCOUNT, m_wcount);
        check32("rnd.ovf", 32'(OVF), 32'(m_ovf));
        if (m_q.size() > 0) check32("rnd.din", D_DIN, m_q[0]);
        req_now = 1'b0;
        if (D_REQ != 2'b00) begin
            req_now = 1'b1;
            check32("rnd.req_code", 32'(D_REQ), 32'(WR));
            check32("rnd.req_while_busy", 32'(prev_busy), 32'd0);
            check32("rnd.req_overlap", xfer_rem, 32'd0);
            e = (prev_size < 4) ? prev_size : 4;
            check32("rnd.elem", D_ELEM, e);
            check32("rnd.adr", D_INITADR, exp_adr);
            if (e < 4) check32("rnd.partial_without_flush", 32'(m_flush), 32'd1);
            exp_adr = (exp_adr + 8 * e) % 64;
            xfer_rem = e;
        end
        if (DONE) begin
            check32("rnd.done_without_flush", 32'(m_flush), 32'd1);
            check32("rnd.done_not_empty", prev_size, 32'd0);
            check32("rnd.done_in_xfer", xfer_rem, 32'd0);
            m_flush = 1'b0;
            done_seen = 1'b1;
        end
        IN_ENQ  = allow_enq && ($urandom_range(0, 99) < 55);
        IN_DATA = $urandom;
        FLUSH   = force_flush || ($urandom_range(0, 99) < 3);
        D_W     = !req_now && (xfer_rem > 0) && ($urandom_range(0, 99) < 70);
        D_BUSY  = (req_now || xfer_rem > 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        prev_size = m_q.size();
        prev_busy = D_BUSY;
        if (FLUSH) m_flush = 1'b1;
        was_full = (m_q.size() == 8);
        if (D_W && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_wcount++;
            xfer_rem--;
        end
        if (IN_ENQ) begin
            if (was_full) m_ovf = 1'b1;
            else m_q.push_back(IN_DATA);
        end
    endtask

    vec_t tbl [41];

    initial begin
        tbl[0]  = mk(1, 32'h1, 0, 0, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h2, 0, 0, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 32'h3, 0, 0, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 32'h4, 0, 0, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 32'h1, 0, 1, 0, 4, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 32'h1, 0, 0, 0, 4, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 1, 1, 32'h2, 0, 0, 0, 4, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 1, 1, 32'h3, 0, 0, 0, 4, 2, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, 1, 32'h4, 0, 0, 0, 4, 3, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4, 4, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 4, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0);
        tbl[12] = mk(1, 32'h11, 0, 0, 0, 1, 32'h11, 0, 0, 0, 4, 4, 0, 0);
        tbl[13] = mk(1, 32'h12, 0, 0, 0, 1, 32'h11, 0, 0, 0, 4, 4, 0, 0);
        tbl[14] = mk(1, 32'h13, 0, 0, 0, 1, 32'h11, 0, 0, 0, 4, 4, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 1, 32'h11, 0, 0, 0, 4, 4, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 1, 32'h11, 0, 1, 32, 3, 4, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 32, 3, 4, 0, 0);
        tbl[18] = mk(0, 0, 0, 1, 1, 1, 32'h12, 0, 0, 32, 3, 5, 0, 0);
        tbl[19] = mk(0, 0, 0, 1, 1, 1, 32'h13, 0, 0, 32, 3, 6, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32, 3, 7, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 3, 7, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 3, 7, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, 3, 7, 0, 0);
        for (int k = 0; k < 8; k++)
            tbl[24 + k] = mk(1, 32'h21 + 32'(k), 0, 0, 1, 1, 32'h21, (k == 7), 0, 32, 3, 7, 0, 0);
        tbl[32] = mk(1, 32'h29, 0, 0, 1, 1, 32'h21, 1, 0, 32, 3, 7, 0, 1);
        tbl[33] = mk(0, 0, 0, 0, 0, 1, 32'h21, 1, 1, 56, 4, 7, 0, 1);
        tbl[34] = mk(0, 0, 0, 0, 1, 1, 32'h21, 1, 0, 56, 4, 7, 0, 1);
        tbl[35] = mk(0, 0, 0, 1, 1, 1, 32'h22, 0, 0, 56, 4, 8, 0, 1);
        tbl[36] = mk(0, 0, 0, 1, 1, 1, 32'h23, 0, 0, 56, 4, 9, 0, 1);
        tbl[37] = mk(0, 0, 0, 1, 1, 1, 32'h24, 0, 0, 56, 4, 10, 0, 1);
        tbl[38] = mk(0, 0, 0, 1, 1, 1, 32'h25, 0, 0, 56, 4, 11, 0, 1);
        tbl[39] = mk(0, 0, 0, 0, 0, 1, 32'h25, 0, 0, 56, 4, 11, 0, 1);
        tbl[40] = mk(0, 0, 0, 0, 0, 1, 32'h25, 0, 1, 24, 4, 11, 0, 1);

        // reset: outputs quiet while held, no requests after release
        RST_X = 1'b0;
        drive_idle();
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_hold");
        RST_X = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check32("reset_idle.req", 32'(D_REQ), 32'd0);
        end

        // single burst, partial flush, overflow, address modulo
        for (int i = 0; i < 41; i++) begin
            @(negedge CLK);
            IN_ENQ = tbl[i].enq; IN_DATA = tbl[i].data; FLUSH = tbl[i].flush;
            D_W = tbl[i].dw; D_BUSY = tbl[i].busy;
            @(posedge CLK);
            #1;
            check32($sformatf("v%0d.full", i), 32'(IN_FULL), 32'(tbl[i].full));
            check32($sformatf("v%0d.req", i), 32'(D_REQ), 32'(tbl[i].req));
            check32($sformatf("v%0d.adr", i), D_INITADR, tbl[i].adr);
            check32($sformatf("v%0d.elem", i), D_ELEM, tbl[i].elem);
            check32($sformatf("v%0d.wcount", i), WCOUNT, tbl[i].wc);
            check32($sformatf("v%0d.done", i), 32'(DONE), 32'(tbl[i].done));
            check32($sformatf("v%0d.ovf", i), 32'(OVF), 32'(tbl[i].ovf));
            if (tbl[i].chk_din) check32($sformatf("v%0d.din", i), D_DIN, tbl[i].din);
        end

        // D_W during REQ is ignored, then reset in the middle of the burst
        @(negedge CLK);
        D_W = 1'b1; D_BUSY = 1'b1;
        @(posedge CLK); #1;
        check32("dw_in_req.wcount", WCOUNT, 32'd11);
        check32("dw_in_req.din", D_DIN, 32'h25);
        @(negedge CLK);
        @(posedge CLK); #1;
        check32("xfer1.wcount", WCOUNT, 32'd12);
        @(negedge CLK);
        @(posedge CLK); #1;
        check32("xfer2.wcount", WCOUNT, 32'd13);
        check32("xfer2.din", D_DIN, 32'h27);
        @(negedge CLK);
        drive_idle();
        RST_X = 1'b0;
        #1;
        check_reset_outputs("mid_xfer_reset");
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check32("post_reset.req", 32'(D_REQ), 32'd0);
        end
        check_reset_outputs("post_reset");

        // flush on an empty buffer: DONE exactly on the second cycle
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        check32("flush_empty.c1", 32'(DONE), 32'd0);
        @(negedge CLK);
        check32("flush_empty.c2", 32'(DONE), 32'd1);
        @(negedge CLK);
        check32("flush_empty.c3", 32'(DONE), 32'd0);
        check32("flush_empty.req", 32'(D_REQ), 32'd0);

        // address wrap with a 64-byte span
        burst(32'h100, 32'd0);
        burst(32'h200, 32'd32);
        burst(32'h300, 32'd0);
        check32("wrap.wcount", WCOUNT, 32'd12);

        // randomized run against the queue model
        @(negedge CLK);
        drive_idle();
        RST_X = 1'b0;
        @(negedge CLK);
        RST_X = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1, 1'b0);
        done_seen = 1'b0;
        rand_cycle(1'b0, 1'b1);
        begin
            bit fin;
            fin = 1'b0;
            for (int c = 0; c < 300 && !fin; c++) begin
                rand_cycle(1'b0, 1'b0);
                if (done_seen && m_q.size() == 0 && xfer_rem == 0) fin = 1'b1;
            end
            if (!fin) begin
                vectors++; miscompares++;
                $display("FAIL drain_timeout: got done_seen=%0d left=%0d expected done with empty buffer",
                         done_seen, m_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
